// File: rtl/coin_pkg.sv
// Shared coin definitions for the vending datapath (acceptor and change dispenser).
package coin_pkg;

  typedef enum logic [1:0] {
    coin_none    = 2'd0,
    coin_nickel  = 2'd1,
    coin_dime    = 2'd2,
    coin_quarter = 2'd3
  } coin_e;

  localparam int unsigned NICKEL_VAL  = 1;
  localparam int unsigned DIME_VAL    = 2;
  localparam int unsigned QUARTER_VAL = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OFFER   = 2'd2
  } acceptor_state_e;

  // Value of a coin in nickel units; 3 bits covers the largest coin.
  function automatic logic [2:0] coin_value(input coin_e c);
    logic [2:0] v;
    case (c)
      coin_nickel:  v = 3'(NICKEL_VAL);
      coin_dime:    v = 3'(DIME_VAL);
      coin_quarter: v = 3'(QUARTER_VAL);
      default:      v = 3'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_slot.sv
// Combinational coin decode plus the accept/reject decision against credit and inventory.
module coin_slot
  import coin_pkg::*;
#(
  parameter int AMT_W = 4,
  parameter int CNT_W = 2
) (
  input  logic             i_enable,
  input  logic             i_coin_valid,
  input  logic [1:0]       i_coin_type,
  input  logic [AMT_W-1:0] i_paid,
  input  logic [CNT_W-1:0] i_quarters,
  input  logic [CNT_W-1:0] i_dimes,
  input  logic [CNT_W-1:0] i_nickels,
  output logic [AMT_W-1:0] o_value,
  output logic [2:0]       o_onehot,
  output logic             o_accept,
  output logic             o_reject
);

  localparam logic [AMT_W:0]   PAID_MAX = (AMT_W+1)'((1 << AMT_W) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  coin_e          w_coin;
  logic [2:0]     w_value;
  logic [AMT_W:0] w_sum;
  logic           w_room;

  assign w_coin  = coin_e'(i_coin_type);
  assign w_value = coin_value(w_coin);
  assign o_value = AMT_W'(w_value);

  // One extra bit on the sum so an overflowing coin is seen rather than wrapped.
  assign w_sum = {1'b0, i_paid} + (AMT_W+1)'(w_value);

  always_comb begin
    o_onehot = 3'b000;
    w_room   = 1'b0;
    case (w_coin)
      coin_nickel: begin
        o_onehot = 3'b001;
        w_room   = (i_nickels != CNT_MAX);
      end
      coin_dime: begin
        o_onehot = 3'b010;
        w_room   = (i_dimes != CNT_MAX);
      end
      coin_quarter: begin
        o_onehot = 3'b100;
        w_room   = (i_quarters != CNT_MAX);
      end
      default: begin
        o_onehot = 3'b000;
        w_room   = 1'b0;
      end
    endcase
  end

  assign o_accept = i_enable && i_coin_valid && (w_coin != coin_none) &&
                    (w_sum <= PAID_MAX) && w_room;
  assign o_reject = i_coin_valid && !o_accept;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: collects coins toward a latched cost and offers the result to the change dispenser.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int AMT_W = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AMT_W-1:0] cost,
  input  logic             coin_valid,
  input  logic [1:0]       coin_type,
  input  logic             cancel,
  input  logic             inv_load,
  input  logic [CNT_W-1:0] inv_q_in,
  input  logic [CNT_W-1:0] inv_d_in,
  input  logic [CNT_W-1:0] inv_n_in,
  output logic             coin_reject,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AMT_W-1:0] cost_out,
  output logic [AMT_W-1:0] paid_out,
  output logic             cancelled,
  output logic [CNT_W-1:0] quarters,
  output logic [CNT_W-1:0] dimes,
  output logic [CNT_W-1:0] nickels
);

  acceptor_state_e r_state, w_stateNext;

  logic [AMT_W-1:0] r_cost, r_paid, r_costOut;
  logic             r_outValid, r_cancelled, r_reject;
  logic [CNT_W-1:0] r_q, r_d, r_n;

  logic [AMT_W-1:0] w_costNext, w_paidNext, w_costOutNext, w_paidSum;
  logic             w_validNext, w_cancelNext;
  logic [CNT_W-1:0] w_qNext, w_dNext, w_nNext;

  logic             w_enable, w_accept, w_slotReject;
  logic [AMT_W-1:0] w_value;
  logic [2:0]       w_onehot;

  // Cancel wins over a coin in the same cycle, so the slot is disabled while cancelling.
  assign w_enable = (r_state == COLLECT) && !cancel;

  coin_slot #(.AMT_W(AMT_W), .CNT_W(CNT_W)) u_slot (
    .i_enable     (w_enable),
    .i_coin_valid (coin_valid),
    .i_coin_type  (coin_type),
    .i_paid       (r_paid),
    .i_quarters   (r_q),
    .i_dimes      (r_d),
    .i_nickels    (r_n),
    .o_value      (w_value),
    .o_onehot     (w_onehot),
    .o_accept     (w_accept),
    .o_reject     (w_slotReject)
  );

  assign w_paidSum = r_paid + w_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext   = r_state;
    w_costNext    = r_cost;
    w_paidNext    = r_paid;
    w_costOutNext = r_costOut;
    w_validNext   = r_outValid;
    w_cancelNext  = r_cancelled;
    w_qNext       = r_q;
    w_dNext       = r_d;
    w_nNext       = r_n;
    case (r_state)
      IDLE: begin
        if (inv_load) begin
          w_qNext = inv_q_in;
          w_dNext = inv_d_in;
          w_nNext = inv_n_in;
        end
        if (start) begin
          w_costNext   = cost;
          w_paidNext   = '0;
          w_cancelNext = 1'b0;
          if (cost == '0) begin
            w_stateNext   = OFFER;
            w_costOutNext = '0;
            w_validNext   = 1'b1;
          end else begin
            w_stateNext = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (cancel) begin
          w_stateNext   = OFFER;
          w_costOutNext = '0;
          w_cancelNext  = 1'b1;
          w_validNext   = 1'b1;
        end else if (w_accept) begin
          w_paidNext = w_paidSum;
          if (w_onehot[0]) w_nNext = r_n + CNT_W'(1);
          if (w_onehot[1]) w_dNext = r_d + CNT_W'(1);
          if (w_onehot[2]) w_qNext = r_q + CNT_W'(1);
          if (w_paidSum >= r_cost) begin
            w_stateNext   = OFFER;
            w_costOutNext = r_cost;
            w_validNext   = 1'b1;
          end
        end
      end
      OFFER: begin
        if (out_ready) begin
          w_stateNext  = IDLE;
          w_validNext  = 1'b0;
          w_cancelNext = 1'b0;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_validNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cost      <= '0;
      r_paid      <= '0;
      r_costOut   <= '0;
      r_outValid  <= 1'b0;
      r_cancelled <= 1'b0;
      r_reject    <= 1'b0;
      r_q         <= '0;
      r_d         <= '0;
      r_n         <= '0;
    end else begin
      r_cost      <= w_costNext;
      r_paid      <= w_paidNext;
      r_costOut   <= w_costOutNext;
      r_outValid  <= w_validNext;
      r_cancelled <= w_cancelNext;
      r_reject    <= w_slotReject;
      r_q         <= w_qNext;
      r_d         <= w_dNext;
      r_n         <= w_nNext;
    end
  end

  assign coin_reject = r_reject;
  assign busy        = (r_state != IDLE);
  assign out_valid   = r_outValid;
  assign cost_out    = r_costOut;
  assign paid_out    = r_paid;
  assign cancelled   = r_cancelled;
  assign quarters    = r_q;
  assign dimes       = r_d;
  assign nickels     = r_n;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed-vector bench for coin_acceptor with hand-computed expectations.
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       rstN = 1'b1;
  logic       start = 1'b0;
  logic [3:0] cost = '0;
  logic       coinValid = 1'b0;
  logic [1:0] coinType = '0;
  logic       cancel = 1'b0;
  logic       invLoad = 1'b0;
  logic [1:0] invQ = '0, invD = '0, invN = '0;
  logic       outReady = 1'b0;
  logic       coinReject, busy, outValid, cancelled;
  logic [3:0] costOut, paidOut;
  logic [1:0] quarters, dimes, nickels;

  int vecCount  = 0;
  int missCount = 0;

  localparam logic [1:0] NONE = 2'd0, NIC = 2'd1, DIM = 2'd2, QTR = 2'd3;

  coin_acceptor #(.AMT_W(4), .CNT_W(2)) dut (
    .clk         (clk),
    .rst_n       (rstN),
    .start       (start),
    .cost        (cost),
    .coin_valid  (coinValid),
    .coin_type   (coinType),
    .cancel      (cancel),
    .inv_load    (invLoad),
    .inv_q_in    (invQ),
    .inv_d_in    (invD),
    .inv_n_in    (invN),
    .coin_reject (coinReject),
    .busy        (busy),
    .out_valid   (outValid),
    .out_ready   (outReady),
    .cost_out    (costOut),
    .paid_out    (paidOut),
    .cancelled   (cancelled),
    .quarters    (quarters),
    .dimes       (dimes),
    .nickels     (nickels)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the capturing edge.
  task automatic applyStimulus(input logic st, input logic [3:0] c, input logic cv,
                               input logic [1:0] ct, input logic can, input logic ld,
                               input logic rdy);
    start     = st;
    cost      = c;
    coinValid = cv;
    coinType  = ct;
    cancel    = can;
    invLoad   = ld;
    outReady  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, NONE, 0, 0, 0);
  endtask

  task automatic loadInv(input logic [1:0] q, input logic [1:0] d, input logic [1:0] n);
    invQ = q; invD = d; invN = n;
    applyStimulus(0, 0, 0, NONE, 0, 1, 0);
  endtask

  initial begin
    #2 rstN = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valid", outValid, 0);
    checkOutput("rst_paid", paidOut, 0);
    checkOutput("rst_costout", costOut, 0);
    checkOutput("rst_reject", coinReject, 0);
    checkOutput("rst_inv", {quarters, dimes, nickels}, 0);
    @(posedge clk); @(posedge clk); #1;
    rstN = 1'b1;
    idleCycle();

    // Dime then quarter completes cost 7.
    loadInv(0, 0, 0);
    applyStimulus(1, 7, 0, NONE, 0, 0, 0);
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_paid0", paidOut, 0);
    applyStimulus(0, 0, 1, DIM, 0, 0, 0);
    checkOutput("t1_paid2", paidOut, 2);
    checkOutput("t1_valid_early", outValid, 0);
    checkOutput("t1_dimes", dimes, 1);
    applyStimulus(0, 0, 1, QTR, 0, 0, 0);
    checkOutput("t1_paid7", paidOut, 7);
    checkOutput("t1_valid", outValid, 1);
    checkOutput("t1_costout", costOut, 7);
    checkOutput("t1_quarters", quarters, 1);
    checkOutput("t1_cancelled", cancelled, 0);
    checkOutput("t1_reject", coinReject, 0);
    applyStimulus(0, 0, 0, NONE, 0, 0, 1);
    checkOutput("t1_done_valid", outValid, 0);
    checkOutput("t1_done_busy", busy, 0);
    checkOutput("t1_paid_kept", paidOut, 7);

    // Overpay with a quarter on cost 3, then stall the handshake.
    applyStimulus(1, 3, 0, NONE, 0, 0, 0);
    applyStimulus(0, 0, 1, QTR, 0, 0, 0);
    checkOutput("t2_paid", paidOut, 5);
    checkOutput("t2_valid", outValid, 1);
    for (int i = 0; i < 4; i++) begin
      idleCycle();
      checkOutput("t2_hold_valid", outValid, 1);
      checkOutput("t2_hold_paid", paidOut, 5);
      checkOutput("t2_hold_cost", costOut, 3);
      checkOutput("t2_hold_q", quarters, 2);
    end
    applyStimulus(0, 0, 0, NONE, 0, 0, 1);
    checkOutput("t2_idle", busy, 0);
    checkOutput("t2_valid_low", outValid, 0);

    // Coin in IDLE is returned.
    applyStimulus(0, 0, 1, NIC, 0, 0, 0);
    checkOutput("idle_reject", coinReject, 1);
    checkOutput("idle_nickels", nickels, 0);

    // Full nickel tube rejects a nickel.
    loadInv(0, 0, 3);
    checkOutput("t3_reject_clear", coinReject, 0);
    applyStimulus(1, 4, 0, NONE, 0, 0, 0);
    applyStimulus(0, 0, 1, NIC, 0, 0, 0);
    checkOutput("t3_reject", coinReject, 1);
    checkOutput("t3_paid", paidOut, 0);
    checkOutput("t3_nickels", nickels, 3);
    idleCycle();
    checkOutput("t3_pulse_end", coinReject, 0);
    applyStimulus(0, 0, 0, NONE, 1, 0, 0);
    checkOutput("t3_cancel_valid", outValid, 1);
    applyStimulus(0, 0, 0, NONE, 0, 0, 1);

    // Three quarters reach the 15-nickel ceiling exactly.
    loadInv(0, 0, 0);
    applyStimulus(1, 15, 0, NONE, 0, 0, 0);
    applyStimulus(0, 0, 1, QTR, 0, 0, 0);
    applyStimulus(0, 0, 1, QTR, 0, 0, 0);
    checkOutput("t4_paid10", paidOut, 10);
    checkOutput("t4_valid10", outValid, 0);
    applyStimulus(0, 0, 1, QTR, 0, 0, 0);
    checkOutput("t4_paid15", paidOut, 15);
    checkOutput("t4_valid", outValid, 1);
    checkOutput("t4_q3", quarters, 3);
    applyStimulus(0, 0, 0, NONE, 0, 0, 1);

    // Quarter at paid 12 would overflow to 17.
    loadInv(0, 0, 0);
    applyStimulus(1, 15, 0, NONE, 0, 0, 0);
    applyStimulus(0, 0, 1, QTR, 0, 0, 0);
    applyStimulus(0, 0, 1, QTR, 0, 0, 0);
    applyStimulus(0, 0, 1, DIM, 0, 0, 0);
    checkOutput("t4b_paid12", paidOut, 12);
    applyStimulus(0, 0, 1, QTR, 0, 0, 0);
    checkOutput("t4b_reject", coinReject, 1);
    checkOutput("t4b_paid_kept", paidOut, 12);
    checkOutput("t4b_q2", quarters, 2);
    checkOutput("t4b_no_offer", outValid, 0);
    applyStimulus(0, 0, 0, NONE, 1, 0, 0);
    applyStimulus(0, 0, 0, NONE, 0, 0, 1);

    // Cancel beats a simultaneous quarter.
    loadInv(0, 0, 0);
    applyStimulus(1, 9, 0, NONE, 0, 0, 0);
    applyStimulus(0, 0, 1, DIM, 0, 0, 0);
    applyStimulus(0, 0, 1, QTR, 1, 0, 0);
    checkOutput("t5_reject", coinReject, 1);
    checkOutput("t5_valid", outValid, 1);
    checkOutput("t5_cancelled", cancelled, 1);
    checkOutput("t5_costout", costOut, 0);
    checkOutput("t5_paid", paidOut, 2);
    checkOutput("t5_quarters", quarters, 0);
    applyStimulus(0, 0, 0, NONE, 1, 0, 0);
    checkOutput("t5_cancel_ignored", cancelled, 1);
    applyStimulus(0, 0, 0, NONE, 0, 0, 1);
    checkOutput("t5_cancel_clear", cancelled, 0);
    checkOutput("t5_valid_low", outValid, 0);

    // Zero cost goes straight to an offer.
    applyStimulus(1, 0, 0, NONE, 0, 0, 0);
    checkOutput("t6_valid", outValid, 1);
    checkOutput("t6_paid", paidOut, 0);
    checkOutput("t6_cancelled", cancelled, 0);
    applyStimulus(0, 0, 0, NONE, 0, 0, 1);
    checkOutput("t6_idle", busy, 0);

    // Asynchronous reset mid-collection.
    loadInv(0, 0, 0);
    applyStimulus(1, 15, 0, NONE, 0, 0, 0);
    applyStimulus(0, 0, 1, QTR, 0, 0, 0);
    applyStimulus(0, 0, 1, NIC, 0, 0, 0);
    checkOutput("t7_paid6", paidOut, 6);
    coinValid = 1'b0;
    coinType  = NONE;
    #2 rstN = 1'b0;
    #1;
    checkOutput("t7_paid", paidOut, 0);
    checkOutput("t7_busy", busy, 0);
    checkOutput("t7_valid", outValid, 0);
    checkOutput("t7_inv", {quarters, dimes, nickels}, 0);
    checkOutput("t7_costout", costOut, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front end of the vending datapath and the counterpart of the change dispenser: it takes coins in, where the dispenser pays coins out.
- Latches a purchase cost and accumulates inserted nickels, dimes and quarters into a paid total, counted in nickel units.
- Tracks the coin inventory and rejects coins it cannot hold.
- When paid >= cost, or on cancel, it offers {cost, paid, inventory} to the downstream change dispenser over a valid/ready handshake.

Parameters:
- AMT_W, 4, width of cost/paid amounts in nickel units (max 15).
- CNT_W, 2, width of each per-denomination inventory counter (max 3).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a purchase; sampled only in IDLE.
- cost  in  AMT_W  purchase price in nickels; captured on start.
- coin_valid  in  1  a coin is presented this cycle.
- coin_type  in  2  coin_none=0, nickel=1, dime=2, quarter=3.
- cancel  in  1  abort the purchase; sampled only in COLLECT.
- inv_load  in  1  load inventory from inv_*_in; honoured only in IDLE.
- inv_q_in, inv_d_in, inv_n_in  in  CNT_W each  initial quarters/dimes/nickels.
- coin_reject  out  1  one-cycle pulse: the coin presented in the previous cycle was returned.
- busy  out  1  state != IDLE.
- out_valid  out  1  offer to the change dispenser.
- out_ready  in  1  change dispenser accepts the offer.
- cost_out  out  AMT_W  captured cost; 0 when the offer results from cancel.
- paid_out  out  AMT_W  accumulated paid total.
- cancelled  out  1  the offer results from cancel.
- quarters, dimes, nickels  out  CNT_W each  current inventory counts.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - cost_reg, paid_out, cost_out = 0.
  - out_valid, coin_reject, cancelled, busy = 0.
  - All inventory counters = 0.
- Coin values in nickels: nickel=1, dime=2, quarter=5, coin_none=0.
- IDLE:
  - inv_load=1 overwrites all three counters at the next edge.
  - start=1 captures cost and clears paid_out.
    - If cost==0, go to OFFER.
    - Otherwise go to COLLECT.
  - inv_load and start in the same cycle: both take effect.
  - A coin arriving in IDLE is rejected.
- COLLECT:
  - A coin is accepted iff all of the following hold:
    - coin_valid=1;
    - coin_type != coin_none;
    - paid_out + value <= 2^AMT_W-1 (computed in AMT_W+1 bits, no wrap);
    - the matching counter < 2^CNT_W-1.
  - On accept, at the next edge: paid_out += value; the matching counter += 1.
  - Otherwise coin_reject=1 in the following cycle. This also applies to coin_valid with coin_none.
  - Transition to OFFER at the edge where the updated paid >= cost_reg. Latency: out_valid rises 1 cycle after the completing coin.
  - Cancel takes priority over a coin in the same cycle: the coin is rejected and the FSM goes to OFFER with cancelled=1 and cost_out=0.
  - start is ignored.
- OFFER:
  - out_valid=1.
  - cost_out, paid_out, cancelled and the counters are held stable until out_valid && out_ready.
  - At the transfer edge, go to IDLE: out_valid=0, cancelled=0; paid_out is retained until the next start.
  - Coins are rejected in OFFER.
  - cancel is ignored in OFFER.
- Inventory is never decremented by this block. Depletion is the dispenser's concern, and the counts are reloaded via inv_load.
- Reset mid-purchase: immediate return to the reset state. Accumulated credit is lost.
- Only coin_reject is a pulse; all other outputs are registered levels.

Decomposition:
- Package coin_pkg holds:
  - coin_e enum (coin_none, coin_nickel, coin_dime, coin_quarter).
  - Constants NICKEL_VAL=1, DIME_VAL=2, QUARTER_VAL=5.
  - acceptor_state_e enum (IDLE, COLLECT, OFFER).
  - The function coin_value(coin_e), shared with the change dispenser.
- One sub-module is natural: coin_slot.
  - Combinational decode of coin_type into its value and a one-hot denomination.
  - Computes accept/reject against paid_out and the inventory.
  - Instantiated once.

Test Plan:
- Reset, then inv_load q=0,d=0,n=0, then start cost=7.
  - Insert dime, then quarter.
  - Required: paid_out=2 then 7; out_valid rises 1 cycle after the quarter; cost_out=7, paid_out=7, dimes=1, quarters=1, cancelled=0.
- start cost=3, insert quarter.
  - Required: paid_out=5, out_valid=1.
  - Hold out_ready=0 for 4 cycles: outputs stable.
  - out_ready=1: IDLE next cycle.
- Inventory nickels preloaded to 3, start cost=4, insert nickel.
  - Required: coin_reject pulse, paid_out=0, nickels=3.
- start cost=15, insert 3 quarters (paid 15).
  - Required: out_valid=1.
  - Separately, with paid_out=12, insert a quarter: rejected (17>15), paid_out stays 12.
- start cost=9, insert dime, then cancel and quarter in the same cycle.
  - Required: quarter rejected; offer with cancelled=1, cost_out=0, paid_out=2.
- start cost=0.
  - Required: out_valid=1 next cycle with paid_out=0.
  - Separately, assert rst_n=0 while in COLLECT with paid_out=6: all outputs 0 immediately, without waiting for a clock edge.
